// File: rtl/imem_loader.sv
// Byte-serial loader for the instruction memory, with a combinational 10-byte fetch window.
// The pipeline is held until a load completes, so no preload at time zero is needed.
module imem_loader #(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  len,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   input  logic [63:0] rd_addr,
   output logic [79:0] rd_window,
   output logic        rd_err,
   output logic        fetch_hold,
   output logic        load_done,
   output logic        load_err,
   output logic [7:0]  byte_count
);

   localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 1);
   localparam logic [8:0]  MAX_LEN   = 9'(MEM_BYTES);
   localparam int          WIN_BYTES = 10;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [7:0]        r_byte_count;
   logic [7:0]        r_len;
   logic [7:0]        w_cnt_inc;
   logic              w_xfer;
   logic              w_load_go;
   logic              w_zero_go;
   logic [7:0]        r_mem [MEM_BYTES];

   // A reset edge never writes memory, even if in_valid is high.
   assign w_xfer    = (r_state == S_LOAD) && in_valid && rst_n;
   assign w_cnt_inc = r_byte_count + 8'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // IDLE, DONE and ERR share the same start decision.
   always_comb begin
      w_state_nxt = r_state;
      w_load_go   = 1'b0;
      w_zero_go   = 1'b0;
      case (r_state)
         S_LOAD: begin
            if (w_xfer && (w_cnt_inc == r_len)) w_state_nxt = S_DONE;
         end
         default: begin
            if (start) begin
               if (len == 8'd0) begin
                  w_state_nxt = S_DONE;
                  w_zero_go   = 1'b1;
               end else if ({1'b0, len} > MAX_LEN) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_state_nxt = S_LOAD;
                  w_load_go   = 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      fetch_hold = 1'b1;
      load_done  = 1'b0;
      load_err   = 1'b0;
      case (r_state)
         S_LOAD:  in_ready = 1'b1;
         S_DONE: begin
            load_done  = 1'b1;
            fetch_hold = 1'b0;
         end
         S_ERR:   load_err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr     <= '0;
         r_byte_count <= '0;
         r_len        <= '0;
      end else if (w_load_go) begin
         r_len        <= len;
         r_wr_ptr     <= '0;
         r_byte_count <= '0;
      end else if (w_zero_go) begin
         r_wr_ptr     <= '0;
         r_byte_count <= '0;
      end else if (w_xfer) begin
         r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
         r_byte_count <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (w_xfer) r_mem[r_wr_ptr] <= in_byte;
   end

   assign byte_count = r_byte_count;

   // Full 64-bit compare: large PCs never alias into the array, and bytes past the end read as zero.
   assign rd_err = rd_addr > LAST_ADDR;

   always_comb begin
      rd_window = '0;
      for (int i = 0; i < WIN_BYTES; i++) begin
         if (!rd_err && ((rd_addr + 64'(i)) <= LAST_ADDR))
            rd_window[8*(WIN_BYTES-1-i) +: 8] = r_mem[rd_addr[ADDR_W-1:0] + ADDR_W'(i)];
      end
   end

endmodule
